fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
//
// PURPOSE
//   Shares one synchronous FIFO write port among NUM_REQ requesters.
//   Each requester has a valid/ready interface; arbitration is round-robin.
//   Optional burst hold lets the winner push up to MAX_BURST beats back-to-back.
//   Drives the FIFO push/wr_data registered and tags each beat with its source ID.
//   Sits between producer engines and the shared FIFO in the buffering subsystem.
//
// PARAMETERS
//   DATA_WIDTH  32  width of each requester's data and of FIFO wr_data
//   NUM_REQ     4   number of requesters (>=2)
//   MAX_BURST   4   max consecutive beats per grant (>=1; 1 = pure round-robin)
//   ID_W        $clog2(NUM_REQ)  derived; width of push_id
//
// PORTS
//   clk              in   1                   rising-edge clock
//   reset            in   1                   asynchronous, active-high reset
//   req_valid        in   NUM_REQ             requester i has a beat on req_data[i]
//   req_data         in   NUM_REQ*DATA_WIDTH  packed; slice i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready        out  NUM_REQ             one-hot/zero; beat i accepted this cycle
//   push             out  1                   registered write strobe to FIFO
//   wr_data          out  DATA_WIDTH          registered FIFO write data
//   push_id          out  ID_W                registered source index of current push
//   fifo_full        in   1                   FIFO full
//   fifo_almost_full in   1                   FIFO holds exactly DEPTH-1 entries
//   arb_busy         out  1                   1 while in BURST state
//
// BEHAVIOUR
//   - Reset (async, any time): push=0, wr_data=0, push_id=0, rr_ptr=0, state=IDLE,
//     beat_cnt=0, arb_busy=0. req_ready=0 while reset is high.
//   - Space check: ok = !fifo_full && !(push && fifo_almost_full).
//     This covers the one-cycle registered-push lag, so the FIFO never overflows.
//   - Handshake: a beat transfers when req_valid[i] && req_ready[i].
//     req_ready is combinational from req_valid, state and ok.
//     Requesters hold data stable until ready.
//   - IDLE: winner g = first i with req_valid[i], scanning from rr_ptr upward
//     mod NUM_REQ. req_ready[g] = ok.
//     On accept with MAX_BURST==1: rr_ptr <= g+1 mod NUM_REQ; stay IDLE.
//     On accept with MAX_BURST>1: owner <= g, beat_cnt <= 1, state <= BURST.
//   - BURST: only the owner can be granted; req_ready[owner] = ok.
//     On accept: beat_cnt++. If beat_cnt reaches MAX_BURST, release.
//     If the owner's req_valid is low, release regardless of ok.
//     Release: rr_ptr <= owner+1 mod NUM_REQ, beat_cnt <= 0, state <= IDLE.
//     The new winner is granted from the next cycle (one idle cycle on handover).
//     Stall (ok=0): state, beat_cnt and rr_ptr hold.
//   - Output latency 1 cycle: push <= accept, wr_data <= accepted data,
//     push_id <= accepted index. When push=0, wr_data and push_id hold.
//   - rr_ptr and owner wrap modulo NUM_REQ (non-power-of-2 NUM_REQ supported).
//     beat_cnt is $clog2(MAX_BURST+1) bits.
//   - At most one req_ready is high per cycle. No requester waits longer than
//     (NUM_REQ-1)*MAX_BURST accepted beats plus stalls.
//
// STRUCTURE
//   - Package fifo_arb_pkg: typedef enum logic {IDLE, BURST} arb_state_t;
//     function rr_next(idx, n).
//   - Sub-module rr_pick (combinational): inputs req vector and rr_ptr;
//     outputs one-hot grant and index.
//   - Top level holds the FSM, counters and output registers.
//
// TESTING (NUM_REQ=4, DATA_WIDTH=32, FIFO depth 16)
//   1. Reset held with req_valid=4'b1111 -> req_ready=0, push=0.
//      After release, the first push has push_id=0.
//   2. MAX_BURST=1, all valid, FIFO never full, data=0xA0+i
//      -> push_id 0,1,2,3,0,...; wr_data matches the source.
//   3. MAX_BURST=4, req1 supplies 0x10..0x13, req2 valid
//      -> four pushes id=1 (0x10..0x13), one idle cycle, then id=2.
//   4. fifo_almost_full=1 while push=1 -> no req_ready that cycle.
//      Hold fifo_full=1 for 3 cycles -> push=0, beat_cnt unchanged;
//      resume with no lost or duplicated beat.
//   5. Burst owner req0 drops valid after 2 beats with req3 valid
//      -> release; req3 is next winner (rr_ptr=1 finds 3); arb_busy falls.
//   6. Assert reset mid-burst (beat 2) -> push=0 immediately.
//      After release: IDLE, rr_ptr=0, no stale push.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first request at or after ptr (mod N).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    grant = '0;
    idx = '0;
    // scan far-to-near so the closest requester to ptr is the last writer
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j -= N;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin sharing of one FIFO write port with optional
// burst hold; push/wr_data/push_id are registered one cycle after acceptance.
module fifo_write_arbiter import fifo_arb_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          push,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [ID_W-1:0]               push_id,
  input  logic                          fifo_full,
  input  logic                          fifo_almost_full,
  output logic                          arb_busy
);
  localparam int BW = $clog2(MAX_BURST + 1);
  arb_state_t state, state_n;
  logic [ID_W-1:0] owner, owner_n, rr_ptr, rr_n, g, sel;
  logic [BW-1:0] beat_cnt, cnt_n;
  logic [NUM_REQ-1:0] grant;
  logic ok, accept;
  rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(grant),
    .idx  (g)
  );
  // a push already in flight consumes the last free slot
  assign ok = !fifo_full && !(push && fifo_almost_full);
  assign arb_busy = state == BURST;
  always_comb begin
    sel = state == BURST ? owner : g;
    req_ready = '0;
    if (!reset && ok) begin
      if (state == IDLE) req_ready = grant;
      else if (req_valid[owner] && beat_cnt != BW'(MAX_BURST)) req_ready[owner] = 1'b1;
    end
    accept = |req_ready;
    state_n = state;
    owner_n = owner;
    rr_n = rr_ptr;
    cnt_n = beat_cnt;
    if (state == IDLE) begin
      if (accept) begin
        if (MAX_BURST == 1) rr_n = ID_W'(rr_next(32'(g), NUM_REQ));
        else begin
          owner_n = g;
          cnt_n = BW'(1);
          state_n = BURST;
        end
      end
    end else if (!req_valid[owner] || beat_cnt == BW'(MAX_BURST)) begin
      rr_n = ID_W'(rr_next(32'(owner), NUM_REQ));
      cnt_n = '0;
      state_n = IDLE;
    end else if (accept) cnt_n = beat_cnt + BW'(1);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      owner <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      push <= 1'b0;
      wr_data <= '0;
      push_id <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_ptr <= rr_n;
      beat_cnt <= cnt_n;
      push <= accept;
      if (accept) begin
        wr_data <= req_data[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
        push_id <= sel;
      end
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed checks of a MAX_BURST=1 and a MAX_BURST=4
// arbiter driven by the same requesters and FIFO flags.
module tb_fifo_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req_valid;
  logic [127:0] req_data;
  logic fifo_full, fifo_almost_full;
  logic [3:0] rdy1, rdy4;
  logic push1, push4, busy1, busy4;
  logic [31:0] wd1, wd4;
  logic [1:0] id1, id4;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(1)) d1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy1), .push(push1), .wr_data(wd1), .push_id(id1),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full), .arb_busy(busy1)
  );
  fifo_write_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) d4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy4), .push(push4), .wr_data(wd4), .push_id(id4),
    .fifo_full(fifo_full), .fifo_almost_full(fifo_almost_full), .arb_busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 4'b1111;
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    fifo_full = 1'b0;
    fifo_almost_full = 1'b0;
    tick();
    tick();
    chk("rst_ready1", 32'(rdy1), 32'h0);
    chk("rst_ready4", 32'(rdy4), 32'h0);
    chk("rst_push1", 32'(push1), 32'h0);
    chk("rst_push4", 32'(push4), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    chk("rst_busy4", 32'(busy4), 32'h0);
    reset = 1'b0;
    #1;
    chk("rr_ready1_first", 32'(rdy1), 32'h1);
    chk("rr_ready4_first", 32'(rdy4), 32'h1);
    // d1 rotates every beat; d4 holds 4 beats, bubbles, then moves to req1
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("rr1_push", 32'(push1), 32'h1);
      chk("rr1_id", 32'(id1), 32'((k - 1) % 4));
      chk("rr1_data", wd1, 32'hA0 + 32'((k - 1) % 4));
      chk("b4_push", 32'(push4), (k == 5 || k == 10) ? 32'h0 : 32'h1);
      if (k != 5 && k != 10) begin
        chk("b4_id", 32'(id4), k <= 4 ? 32'h0 : 32'h1);
        chk("b4_data", wd4, k <= 4 ? 32'hA0 : 32'hA1);
      end
      chk("b4_busy", 32'(busy4), (k == 5 || k == 10) ? 32'h0 : 32'h1);
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b0110;
    req_data[32 +: 32] = 32'h10;
    req_data[64 +: 32] = 32'h22;
    #1;
    chk("burst_ready_req1", 32'(rdy4), 32'h2);
    for (int b = 0; b < 4; b++) begin
      tick();
      chk("burst_push", 32'(push4), 32'h1);
      chk("burst_id", 32'(id4), 32'h1);
      chk("burst_data", wd4, 32'h10 + 32'(b));
      req_data[32 +: 32] = 32'h11 + 32'(b);
    end
    req_valid = 4'b0100;
    tick();
    chk("handover_idle_push", 32'(push4), 32'h0);
    chk("handover_ready_req2", 32'(rdy4), 32'h4);
    tick();
    chk("handover_push", 32'(push4), 32'h1);
    chk("handover_id", 32'(id4), 32'h2);
    chk("handover_data", wd4, 32'h22);
    req_data[64 +: 32] = 32'h23;

    fifo_almost_full = 1'b1;
    #1;
    chk("afull_ready4", 32'(rdy4), 32'h0);
    chk("afull_ready1", 32'(rdy1), 32'h0);
    tick();
    chk("afull_push4", 32'(push4), 32'h0);
    fifo_almost_full = 1'b0;
    fifo_full = 1'b1;
    #1;
    chk("full_ready4", 32'(rdy4), 32'h0);
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("full_push4", 32'(push4), 32'h0);
      chk("full_busy4", 32'(busy4), 32'h1);
    end
    fifo_full = 1'b0;
    #1;
    chk("resume_ready4", 32'(rdy4), 32'h4);
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("resume_push", 32'(push4), 32'h1);
      chk("resume_id", 32'(id4), 32'h2);
      chk("resume_data", wd4, 32'h23 + 32'(b));
      req_data[64 +: 32] = 32'h24 + 32'(b);
    end
    req_valid = 4'b0000;
    chk("burst_full_busy", 32'(busy4), 32'h1);
    chk("burst_full_ready", 32'(rdy4), 32'h0);
    tick();
    chk("burst_end_push", 32'(push4), 32'h0);
    chk("burst_end_busy", 32'(busy4), 32'h0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1001;
    req_data[0 +: 32] = 32'h50;
    req_data[96 +: 32] = 32'h53;
    #1;
    chk("drop_ready_req0", 32'(rdy4), 32'h1);
    tick();
    chk("drop_b1_id", 32'(id4), 32'h0);
    chk("drop_b1_data", wd4, 32'h50);
    req_data[0 +: 32] = 32'h51;
    tick();
    chk("drop_b2_data", wd4, 32'h51);
    req_valid = 4'b1000;
    #1;
    chk("drop_release_ready", 32'(rdy4), 32'h0);
    chk("drop_release_busy", 32'(busy4), 32'h1);
    tick();
    chk("drop_idle_push", 32'(push4), 32'h0);
    chk("drop_idle_busy", 32'(busy4), 32'h0);
    chk("drop_ready_req3", 32'(rdy4), 32'h8);
    tick();
    chk("drop_next_push", 32'(push4), 32'h1);
    chk("drop_next_id", 32'(id4), 32'h3);
    chk("drop_next_data", wd4, 32'h53);
    req_data[96 +: 32] = 32'h54;
    tick();
    chk("mid_b2_data", wd4, 32'h54);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_push4", 32'(push4), 32'h0);
    chk("mid_rst_push1", 32'(push1), 32'h0);
    chk("mid_rst_busy4", 32'(busy4), 32'h0);
    chk("mid_rst_ready4", 32'(rdy4), 32'h0);
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    req_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    #1;
    chk("post_rst_push4", 32'(push4), 32'h0);
    chk("post_rst_ready4", 32'(rdy4), 32'h1);
    tick();
    chk("post_rst_id4", 32'(id4), 32'h0);
    chk("post_rst_data4", wd4, 32'hA0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
